vector_alu_sequencer: RTL and testbench

- Upstream and downstream neighbour of the scalar ALU (WIDTH-bit operands, 2-bit ALUControl, 2-bit flags {Z,N}).
- Accepts one vector instruction of LANES packed elements and feeds the external combinational ALU one lane per cycle.
- Captures each lane's result and flags, then presents the assembled result vector with per-lane and aggregate flags on a valid/ready output.

---
 rtl/vector_alu_sequencer.sv | 139 +++++++++++++
 tb/tb_vector_alu_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: issues one packed vector instruction to an external
// combinational scalar ALU one lane per cycle, collects each lane's result
// and {Z,N} flags, and presents the assembled vector on a valid/ready output.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. The producer holds its payload stable while
// valid=1 and ready=0. Here start_ready is 1 only in IDLE. out_valid is 1
// only in DONE, and the result payload stays frozen until the transfer.
// start_ready rises one cycle after the output transfer, never in the same
// cycle.
module vector_alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [1:0]               op,
  input  logic [LANES*WIDTH-1:0]   vec_a,
  input  logic [LANES*WIDTH-1:0]   vec_b,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [1:0]               alu_ctrl,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic [1:0]               alu_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   vec_result,
  output logic [2*LANES-1:0]       lane_flags,
  output logic                     any_n,
  output logic                     all_z,
  output logic [1:0]               dbg_state
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CW-1:0]          cnt_q;
  logic [LANES*WIDTH-1:0] a_q;
  logic [LANES*WIDTH-1:0] b_q;
  logic [1:0]             op_q;
  logic                   last_lane;

  assign last_lane = (cnt_q == CW'(LANES - 1));
  assign dbg_state = state_q;

  // State register; reset discards any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus handshake and ALU-drive outputs (ALU idles at 0/add).
  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    out_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctrl    = 2'b00;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        alu_a    = a_q[int'(cnt_q)*WIDTH +: WIDTH];
        alu_b    = b_q[int'(cnt_q)*WIDTH +: WIDTH];
        alu_ctrl = op_q;
        if (last_lane) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on acceptance and per-lane result/flag collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 2'b00;
      vec_result <= '0;
      lane_flags <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q        <= vec_a;
            b_q        <= vec_b;
            op_q       <= op;
            cnt_q      <= '0;
            vec_result <= '0;
            lane_flags <= '0;
          end
        end
        RUN: begin
          vec_result[int'(cnt_q)*WIDTH +: WIDTH] <= alu_result;
          lane_flags[int'(cnt_q)*2 +: 2]         <= alu_flags;
          cnt_q                                  <= cnt_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Aggregate flags from the registered lane flags: [0]=N, [1]=Z per lane.
  always_comb begin
    any_n = 1'b0;
    all_z = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      any_n = any_n | lane_flags[2*i];
      all_z = all_z & lane_flags[2*i+1];
    end
  end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Testbench for vector_alu_sequencer with a behavioural scalar ALU attached.
module tb_vector_alu_sequencer;

  localparam int W  = 4;
  localparam int L  = 4;
  localparam int VW = W * L;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [1:0]    op = 2'b00;
  logic [VW-1:0] vec_a = '0;
  logic [VW-1:0] vec_b = '0;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [1:0]    alu_ctrl;
  logic [W-1:0]  alu_result;
  logic [1:0]    alu_flags;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] vec_result;
  logic [2*L-1:0] lane_flags;
  logic          any_n;
  logic          all_z;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [VW-1:0]  exp_q[$];
  logic [2*L-1:0] expf_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  vector_alu_sequencer #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .vec_a(vec_a), .vec_b(vec_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .vec_result(vec_result), .lane_flags(lane_flags),
    .any_n(any_n), .all_z(all_z), .dbg_state(dbg_state)
  );

  // Attached scalar ALU: 00 add, 01 sub, 11 shift left, 10 pass A.
  always_comb begin
    case (alu_ctrl)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b11:   alu_result = alu_a << alu_b;
      default: alu_result = alu_a;
    endcase
    alu_flags = {alu_result == '0, alu_result[W-1]};
  end

  // ---------------- reference model ----------------
  function automatic void ref_model(input logic [1:0] o, input logic [VW-1:0] a,
                                    input logic [VW-1:0] b, output logic [VW-1:0] res,
                                    output logic [2*L-1:0] fl);
    int x, y, r, m;
    m   = 1 << W;
    res = '0;
    fl  = '0;
    for (int i = 0; i < L; i++) begin
      x = int'((a >> (i*W)) & VW'(m - 1));
      y = int'((b >> (i*W)) & VW'(m - 1));
      case (o)
        2'b00:   r = (x + y) % m;
        2'b01:   r = (x - y + m) % m;
        2'b11:   r = (x << y) % m;
        default: r = x;
      endcase
      res = res | (VW'(r) << (i*W));
      fl  = fl | ((2*L)'({r == 0, r >= m/2}) << (2*i));
    end
  endfunction

  function automatic logic model_any_n(input logic [2*L-1:0] fl);
    model_any_n = 1'b0;
    for (int i = 0; i < L; i++) if (fl[2*i]) model_any_n = 1'b1;
  endfunction

  function automatic logic model_all_z(input logic [2*L-1:0] fl);
    int cnt;
    cnt = 0;
    for (int i = 0; i < L; i++) if (fl[2*i+1]) cnt++;
    model_all_z = (cnt == L);
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one instruction, records what the ALU sees each RUN cycle and
  // returns the accept-to-out_valid latency in cycles (-1 if never accepted).
  task automatic do_instr(input logic [1:0] o, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          output logic [VW-1:0] sa, output logic [VW-1:0] sb,
                          output logic [2*L-1:0] sc, output int lat);
    logic rdy;
    int   w;
    sa = '0; sb = '0; sc = '0; lat = -1;
    op = o; vec_a = a; vec_b = b; start_valid = 1'b1;
    rdy = 1'b0; w = 0;
    while (!rdy && w < 20) begin
      rdy = start_ready;
      @(posedge clk); #1;
      w++;
    end
    start_valid = 1'b0;
    op    = 2'($urandom);
    vec_a = VW'($urandom);
    vec_b = VW'($urandom);
    if (!rdy) return;
    for (int i = 0; i < L; i++) begin
      sa[i*W +: W] = alu_a;
      sb[i*W +: W] = alu_b;
      sc[2*i +: 2] = alu_ctrl;
      @(posedge clk); #1;
    end
    lat = L + 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input int delay);
    out_ready = 1'b0;
    repeat (delay) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL rst_state got %0d want 0", dbg_state); else n_pass++;
    n_checks++; if (start_ready !== 1'b1) $display("FAIL rst_start_ready got %b want 1", start_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (vec_result !== '0) $display("FAIL rst_vec_result got %h want 0", vec_result); else n_pass++;
    n_checks++; if (lane_flags !== '0) $display("FAIL rst_lane_flags got %h want 0", lane_flags); else n_pass++;
    n_checks++; if ({any_n, all_z} !== 2'b00) $display("FAIL rst_aggr got %b want 00", {any_n, all_z}); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_ctrl} !== '0) $display("FAIL rst_alu_drive got %h/%h/%b want 0", alu_a, alu_b, alu_ctrl); else n_pass++;
  endtask

  task automatic test_directed();
    logic [1:0]     t_op[3] = '{2'b00, 2'b01, 2'b11};
    logic [VW-1:0]  t_a[3]  = '{16'h00AA, 16'hDDDD, 16'h4444};
    logic [VW-1:0]  t_b[3]  = '{16'h0019, 16'hDDDD, 16'h2121};
    logic [VW-1:0]  t_r[3]  = '{16'h00B3, 16'h0000, 16'h0808};
    logic [2*L-1:0] t_f[3]  = '{8'hA4, 8'hAA, 8'h99};
    logic           t_n[3]  = '{1'b1, 1'b0, 1'b1};
    logic           t_z[3]  = '{1'b0, 1'b1, 1'b0};
    logic [VW-1:0]  sa, sb;
    logic [2*L-1:0] sc;
    int             lat;
    for (int k = 0; k < 3; k++) begin
      do_instr(t_op[k], t_a[k], t_b[k], sa, sb, sc, lat);
      n_checks++; if (lat != L + 1) $display("FAIL dir_latency[%0d] got %0d want %0d", k, lat, L + 1); else n_pass++;
      n_checks++; if (sa !== t_a[k] || sb !== t_b[k]) $display("FAIL dir_lane_order[%0d] got %h/%h want %h/%h", k, sa, sb, t_a[k], t_b[k]); else n_pass++;
      n_checks++; if (sc !== {L{t_op[k]}}) $display("FAIL dir_alu_ctrl[%0d] got %h want %h", k, sc, {L{t_op[k]}}); else n_pass++;
      n_checks++; if (vec_result !== t_r[k]) $display("FAIL dir_result[%0d] got %h want %h", k, vec_result, t_r[k]); else n_pass++;
      n_checks++; if (lane_flags !== t_f[k]) $display("FAIL dir_flags[%0d] got %h want %h", k, lane_flags, t_f[k]); else n_pass++;
      n_checks++; if (any_n !== t_n[k] || all_z !== t_z[k]) $display("FAIL dir_aggr[%0d] got %b%b want %b%b", k, any_n, all_z, t_n[k], t_z[k]); else n_pass++;
      consume(0);
      n_checks++; if (out_valid !== 1'b0 || start_ready !== 1'b1) $display("FAIL dir_release[%0d] got v=%b r=%b want v=0 r=1", k, out_valid, start_ready); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0]  a, b, sa, sb, er;
    logic [2*L-1:0] sc, ef;
    int             lat;
    a = VW'($urandom); b = VW'($urandom);
    ref_model(2'b00, a, b, er, ef);
    do_instr(2'b00, a, b, sa, sb, sc, lat);
    n_checks++; if (lat != L + 1) $display("FAIL bp_latency got %0d want %0d", lat, L + 1); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      out_ready   = 1'b0;
      start_valid = ~start_valid;
      vec_a       = VW'($urandom);
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || start_ready !== 1'b0) $display("FAIL bp_hold_hs[%0d] got v=%b r=%b want v=1 r=0", c, out_valid, start_ready); else n_pass++;
      n_checks++; if (vec_result !== er || lane_flags !== ef) $display("FAIL bp_hold_data[%0d] got %h/%h want %h/%h", c, vec_result, lane_flags, er, ef); else n_pass++;
    end
    start_valid = 1'b0;
    out_ready   = 1'b1;
    n_checks++; if (start_ready !== 1'b0) $display("FAIL bp_ready_same_cycle got %b want 0", start_ready); else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || start_ready !== 1'b1) $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, start_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0]  a, b, sa, sb, er;
    logic [2*L-1:0] sc, ef;
    int             lat, spurious;
    op = 2'b00; vec_a = VW'($urandom); vec_b = VW'($urandom); start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL mid_rst_state got %0d want 0", dbg_state); else n_pass++;
    n_checks++; if (start_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL mid_rst_hs got r=%b v=%b want r=1 v=0", start_ready, out_valid); else n_pass++;
    n_checks++; if (vec_result !== '0 || lane_flags !== '0) $display("FAIL mid_rst_data got %h/%h want 0/0", vec_result, lane_flags); else n_pass++;
    spurious = 0;
    repeat (L + 2) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) spurious++;
    end
    n_checks++; if (spurious != 0) $display("FAIL mid_rst_no_output got %0d valid cycles want 0", spurious); else n_pass++;
    a = VW'($urandom); b = VW'($urandom);
    ref_model(2'b00, a, b, er, ef);
    do_instr(2'b00, a, b, sa, sb, sc, lat);
    n_checks++; if (lat != L + 1) $display("FAIL mid_after_latency got %0d want %0d", lat, L + 1); else n_pass++;
    n_checks++; if (vec_result !== er || lane_flags !== ef) $display("FAIL mid_after_data got %h/%h want %h/%h", vec_result, lane_flags, er, ef); else n_pass++;
    consume(1);
  endtask

  task automatic test_random();
    logic [1:0]     o;
    logic [VW-1:0]  a, b, sa, sb, er;
    logic [2*L-1:0] sc, ef;
    int             lat;
    for (int k = 0; k < 12; k++) begin
      o = 2'($urandom_range(0, 3));
      a = VW'($urandom); b = VW'($urandom);
      ref_model(o, a, b, er, ef);
      exp_q.push_back(er);
      expf_q.push_back(ef);
      do_instr(o, a, b, sa, sb, sc, lat);
      er = exp_q.pop_front();
      ef = expf_q.pop_front();
      n_checks++; if (lat != L + 1) $display("FAIL rnd_latency[%0d] got %0d want %0d", k, lat, L + 1); else n_pass++;
      n_checks++; if (sa !== a || sb !== b || sc !== {L{o}}) $display("FAIL rnd_alu_drive[%0d] got %h/%h/%h want %h/%h/%h", k, sa, sb, sc, a, b, {L{o}}); else n_pass++;
      n_checks++; if (vec_result !== er) $display("FAIL rnd_result[%0d] op=%b got %h want %h", k, o, vec_result, er); else n_pass++;
      n_checks++; if (lane_flags !== ef) $display("FAIL rnd_flags[%0d] got %h want %h", k, lane_flags, ef); else n_pass++;
      n_checks++; if (any_n !== model_any_n(ef) || all_z !== model_all_z(ef)) $display("FAIL rnd_aggr[%0d] got %b%b want %b%b", k, any_n, all_z, model_any_n(ef), model_all_z(ef)); else n_pass++;
      consume($urandom_range(0, 3));
      n_checks++; if (out_valid !== 1'b0 || start_ready !== 1'b1) $display("FAIL rnd_release[%0d] got v=%b r=%b want v=0 r=1", k, out_valid, start_ready); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]     iop[3];
    logic [VW-1:0]  ia[3], ib[3], er;
    logic [2*L-1:0] ef;
    for (int j = 0; j < 3; j++) begin
      iop[j] = 2'($urandom_range(0, 3));
      ia[j]  = VW'($urandom);
      ib[j]  = VW'($urandom);
    end
    op = iop[0]; vec_a = ia[0]; vec_b = ib[0];
    start_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 3 * (L + 2); c++) begin
      int ph, j;
      ph = c % (L + 2);
      j  = c / (L + 2);
      if (ph == 0) begin
        n_checks++; if (start_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_accept[%0d] got r=%b v=%b want r=1 v=0", j, start_ready, out_valid); else n_pass++;
      end else if (ph <= L) begin
        n_checks++;
        if (alu_a !== ia[j][(ph-1)*W +: W] || alu_b !== ib[j][(ph-1)*W +: W] || alu_ctrl !== iop[j] || start_ready !== 1'b0 || out_valid !== 1'b0)
          $display("FAIL b2b_lane[%0d.%0d] got %h/%h/%b r=%b v=%b want %h/%h/%b r=0 v=0", j, ph - 1, alu_a, alu_b, alu_ctrl, start_ready, out_valid,
                   ia[j][(ph-1)*W +: W], ib[j][(ph-1)*W +: W], iop[j]);
        else n_pass++;
      end else begin
        ref_model(iop[j], ia[j], ib[j], er, ef);
        n_checks++; if (out_valid !== 1'b1 || vec_result !== er || lane_flags !== ef) $display("FAIL b2b_result[%0d] got v=%b %h/%h want v=1 %h/%h", j, out_valid, vec_result, lane_flags, er, ef); else n_pass++;
      end
      @(posedge clk); #1;
      if (ph == 0 && j + 1 < 3) begin
        op = iop[j+1]; vec_a = ia[j+1]; vec_b = ib[j+1];
      end
      if (ph == L + 1 && j == 2) start_valid = 1'b0;
    end
    out_ready = 1'b0;
    n_checks++; if (start_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_end got r=%b v=%b want r=1 v=0", start_ready, out_valid); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
